// File: rtl/eth_pkg.sv
// eth_pkg: shared types, status bit indices and RMII constants for the Ethernet receive path
package eth_pkg;
  typedef enum logic [2:0] {ST_WAIT, ST_IDLE, ST_PRE, ST_DATA, ST_DROP, ST_CHECK} state_t;
  localparam int ERR_CRC   = 0;
  localparam int ERR_RXERR = 1;
  localparam int ERR_ALIGN = 2;
  localparam int ERR_RUNT  = 3;
  localparam int ERR_LONG  = 4;
  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;
  localparam logic [2:0] PRE_MIN   = 3'd4;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/crc32.sv
// crc32: byte-wide Ethernet CRC-32; crc is the FCS word with the first wire byte in the top byte
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] state_q;
  logic [31:0] fin;
  assign fin = ~state_q;
  assign crc = {fin[7:0], fin[15:8], fin[23:16], fin[31:24]};
  // accumulate one byte per vld, restarting from all-ones on rst
  always_ff @(posedge clk) begin
    if (rst) state_q <= '1;
    else if (vld) state_q <= crc32_byte(state_q, data);
  end
endmodule

// File: rtl/eth_rx_ctrl.sv
// eth_rx_ctrl: RMII receive framing, FCS stripping and checking, per-frame status and counters
module eth_rx_ctrl
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eth_crsdv,
  input  logic             eth_rxerr,
  input  logic [1:0]       eth_rxd,
  output logic [7:0]       m_data,
  output logic             m_vld,
  output logic             m_sof,
  output logic             st_vld,
  output logic [10:0]      st_len,
  output logic [4:0]       st_err,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  state_t state_q, state_d;
  logic [2:0] pre_q, pre_d;
  logic [7:0] sr_q, sr_d, byte_w;
  logic [1:0] dcnt_q, dcnt_d;
  logic [10:0] bcnt_q, bcnt_d, bnext;
  logic [3:0][7:0] dl_q, dl_d;
  logic rxerr_q, rxerr_d, align_q, align_d, long_q, long_d;
  logic [7:0] m_data_q, m_data_d;
  logic m_vld_q, m_vld_d, m_sof_q, m_sof_d, st_vld_q, st_vld_d;
  logic [10:0] st_len_q, st_len_d;
  logic [4:0] st_err_q, st_err_d;
  logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d;
  logic crc_rst;
  logic [31:0] crc_w;
  assign byte_w  = {eth_rxd, sr_q[7:2]};
  assign bnext   = bcnt_q + 11'd1;
  assign crc_rst = rst || state_q == ST_IDLE || state_q == ST_PRE;
  assign m_data   = m_data_q;
  assign m_vld    = m_vld_q;
  assign m_sof    = m_sof_q;
  assign st_vld   = st_vld_q;
  assign st_len   = st_len_q;
  assign st_err   = st_err_q;
  assign cnt_good = good_q;
  assign cnt_bad  = bad_q;
  crc32 u_crc (.clk(clk), .rst(crc_rst), .vld(m_vld_q), .data(m_data_q), .crc(crc_w));
  // next state, byte assembly, delay line, payload output and frame status
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    sr_d     = sr_q;
    dcnt_d   = dcnt_q;
    bcnt_d   = bcnt_q;
    dl_d     = dl_q;
    rxerr_d  = rxerr_q;
    align_d  = align_q;
    long_d   = long_q;
    m_data_d = m_data_q;
    m_vld_d  = 1'b0;
    m_sof_d  = 1'b0;
    st_vld_d = 1'b0;
    st_len_d = st_len_q;
    st_err_d = st_err_q;
    good_d   = st_vld_q && st_err_q == '0 && !(&good_q) ? good_q + CNT_W'(1) : good_q;
    bad_d    = st_vld_q && st_err_q != '0 && !(&bad_q) ? bad_q + CNT_W'(1) : bad_q;
    case (state_q)
      ST_WAIT: state_d = eth_crsdv ? ST_WAIT : ST_IDLE;
      ST_IDLE: begin
        pre_d   = '0;
        state_d = eth_crsdv ? ST_PRE : ST_IDLE;
      end
      ST_PRE: begin
        if (!eth_crsdv) state_d = ST_IDLE;
        else if (eth_rxd == DIBIT_PRE) pre_d = pre_q >= PRE_MIN ? pre_q : pre_q + 3'd1;
        else if (eth_rxd == DIBIT_SFD && pre_q >= PRE_MIN) begin
          state_d = ST_DATA;
          dcnt_d  = '0;
          bcnt_d  = '0;
          rxerr_d = 1'b0;
          align_d = 1'b0;
          long_d  = 1'b0;
        end else if (eth_rxd != 2'b00) state_d = ST_WAIT;
      end
      ST_DATA: begin
        rxerr_d = rxerr_q | eth_rxerr;
        if (!eth_crsdv) begin
          state_d = ST_CHECK;
          align_d = dcnt_q != 2'd0;
        end else begin
          sr_d   = byte_w;
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            if (bnext > MAX_L) begin
              long_d  = 1'b1;
              state_d = ST_DROP;
            end else begin
              bcnt_d = bnext;
              dl_d   = {dl_q[2:0], byte_w};
              if (bcnt_q >= 11'd4) begin
                m_vld_d  = 1'b1;
                m_sof_d  = bcnt_q == 11'd4;
                m_data_d = dl_q[3];
              end
            end
          end
        end
      end
      ST_DROP: state_d = eth_crsdv ? ST_DROP : ST_CHECK;
      ST_CHECK: begin
        st_vld_d            = 1'b1;
        st_len_d            = bcnt_q >= 11'd4 ? bcnt_q - 11'd4 : '0;
        st_err_d            = '0;
        st_err_d[ERR_CRC]   = !long_q && (bcnt_q < 11'd4 || dl_q != crc_w);
        st_err_d[ERR_RXERR] = rxerr_q;
        st_err_d[ERR_ALIGN] = align_q;
        st_err_d[ERR_RUNT]  = bcnt_q < MIN_L;
        st_err_d[ERR_LONG]  = long_q;
        dl_d                = '0;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_WAIT;
    else state_q <= state_d;
  end
  // datapath, flags, outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      sr_q     <= '0;
      dcnt_q   <= '0;
      bcnt_q   <= '0;
      dl_q     <= '0;
      rxerr_q  <= 1'b0;
      align_q  <= 1'b0;
      long_q   <= 1'b0;
      m_data_q <= '0;
      m_vld_q  <= 1'b0;
      m_sof_q  <= 1'b0;
      st_vld_q <= 1'b0;
      st_len_q <= '0;
      st_err_q <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      sr_q     <= sr_d;
      dcnt_q   <= dcnt_d;
      bcnt_q   <= bcnt_d;
      dl_q     <= dl_d;
      rxerr_q  <= rxerr_d;
      align_q  <= align_d;
      long_q   <= long_d;
      m_data_q <= m_data_d;
      m_vld_q  <= m_vld_d;
      m_sof_q  <= m_sof_d;
      st_vld_q <= st_vld_d;
      st_len_q <= st_len_d;
      st_err_q <= st_err_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end
endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb_eth_rx_ctrl: randomized RMII frames checked against a frame-level reference model
module tb_eth_rx_ctrl;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  logic clk, rst, eth_crsdv, eth_rxerr;
  logic [1:0] eth_rxd;
  logic [7:0] m_data;
  logic m_vld, m_sof, st_vld;
  logic [10:0] st_len;
  logic [4:0] st_err;
  logic [15:0] cnt_good, cnt_bad;
  eth_rx_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .eth_crsdv(eth_crsdv), .eth_rxerr(eth_rxerr), .eth_rxd(eth_rxd),
    .m_data(m_data), .m_vld(m_vld), .m_sof(m_sof), .st_vld(st_vld), .st_len(st_len),
    .st_err(st_err), .cnt_good(cnt_good), .cnt_bad(cnt_bad)
  );
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_vld = -1, gap_bad = 0;
  int exp_good = 0, exp_bad = 0;
  bit want_sof, want_st;
  logic [7:0] frame_q[$];
  logic [7:0] got_b[$], exp_b[$];
  logic [15:0] st_got[$], st_exp[$];
  int st_cyc[$], drop_q[$], sof_got[$], sfd_q[$];
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  always @(posedge clk) begin
    cyc++;
    #1;
    if (m_vld) begin
      got_b.push_back(m_data);
      if (m_sof) sof_got.push_back(cyc);
      else if (last_vld >= 0 && cyc - last_vld != 4) gap_bad++;
      last_vld = cyc;
    end
    if (st_vld) begin
      st_got.push_back({st_len, st_err});
      st_cyc.push_back(cyc);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c, r;
    logic fb;
    c = '1;
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ frame_q[i][b];
        c = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return ~r;
  endfunction
  task automatic make_frame(input int npay, input bit seq);
    logic [31:0] f;
    frame_q.delete();
    for (int i = 0; i < npay; i++) frame_q.push_back(seq ? 8'(i) : 8'($urandom));
    f = fcs_of(npay);
    for (int i = 0; i < 4; i++) frame_q.push_back(f[8*i +: 8]);
  endtask
  task automatic make_raw(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
  endtask
  task automatic expect_frame(input bit ok_pre, input int extra, input int err_byte, input int rst_at);
    int n, emit;
    bit long_f, crc_e;
    logic [4:0] e;
    logic [31:0] w;
    n = frame_q.size();
    want_sof = 0;
    want_st = 0;
    if (!ok_pre) return;
    if (rst_at >= 0) begin
      emit = rst_at > 4 ? rst_at - 4 : 0;
      for (int i = 0; i < emit; i++) exp_b.push_back(frame_q[i]);
      want_sof = emit > 0;
      exp_good = 0;
      exp_bad = 0;
      return;
    end
    long_f = n > MAX_LEN;
    emit = long_f ? MAX_LEN - 4 : (n > 4 ? n - 4 : 0);
    for (int i = 0; i < emit; i++) exp_b.push_back(frame_q[i]);
    crc_e = 0;
    if (!long_f) begin
      if (n < 4) crc_e = 1;
      else begin
        w = {frame_q[n-4], frame_q[n-3], frame_q[n-2], frame_q[n-1]};
        crc_e = {w[7:0], w[15:8], w[23:16], w[31:24]} != fcs_of(n - 4);
      end
    end
    e = {long_f, n < MIN_LEN, !long_f && (extra % 4) != 0, err_byte >= 0, crc_e};
    st_exp.push_back({11'(emit), e});
    if (e == 0) exp_good++;
    else exp_bad++;
    want_st = 1;
    want_sof = emit > 0;
  endtask
  task automatic drive(input logic [1:0] d, input logic dv, input logic er, input logic r);
    @(negedge clk);
    eth_rxd = d;
    eth_crsdv = dv;
    eth_rxerr = er;
    rst = r;
  endtask
  task automatic send_frame(input int npre, input int extra, input int err_byte, input int rst_at, input int gap);
    logic [7:0] b;
    for (int i = 0; i < npre; i++) drive(2'b01, 1, 0, 0);
    drive(2'b11, 1, 0, 0);
    if (want_sof) sfd_q.push_back(cyc);
    for (int i = 0; i < frame_q.size(); i++) begin
      b = frame_q[i];
      for (int k = 0; k < 4; k++) drive(b[2*k +: 2], 1, i == err_byte && k == 0, i == rst_at && k == 0);
    end
    for (int k = 0; k < extra; k++) drive(2'($urandom), 1, 0, 0);
    drive(2'b00, 0, 0, 0);
    if (want_st) drop_q.push_back(cyc);
    for (int i = 1; i < gap; i++) drive(2'b00, 0, 0, 0);
  endtask
  task automatic settle();
    int bad;
    logic [15:0] g, e;
    for (int i = 0; i < 40 && st_got.size() < st_exp.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("st_count", st_got.size(), st_exp.size());
    while (st_got.size() > 0 && st_exp.size() > 0) begin
      g = st_got.pop_front();
      e = st_exp.pop_front();
      check("st_len", 32'(g[15:5]), 32'(e[15:5]));
      check("st_err", 32'(g[4:0]), 32'(e[4:0]));
    end
    st_got.delete();
    st_exp.delete();
    bad = 0;
    if (st_cyc.size() != drop_q.size()) bad++;
    else foreach (st_cyc[i]) if (st_cyc[i] - drop_q[i] != 2) bad++;
    check("st_timing", bad, 0);
    st_cyc.delete();
    drop_q.delete();
    check("m_count", got_b.size(), exp_b.size());
    bad = 0;
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) if (got_b[i] !== exp_b[i]) bad++;
    check("m_data_bad", bad, 0);
    got_b.delete();
    exp_b.delete();
    bad = 0;
    if (sof_got.size() != sfd_q.size()) bad++;
    else foreach (sof_got[i]) if (sof_got[i] - sfd_q[i] != 21) bad++;
    check("sof_latency", bad, 0);
    sof_got.delete();
    sfd_q.delete();
    check("vld_gap_bad", gap_bad, 0);
    gap_bad = 0;
    check("cnt_good", 32'(cnt_good), exp_good);
    check("cnt_bad", 32'(cnt_bad), exp_bad);
  endtask
  initial begin
    int n, extra, eb, p;
    rst = 1;
    eth_crsdv = 0;
    eth_rxerr = 0;
    eth_rxd = 0;
    repeat (3) @(negedge clk);
    check("rst_m_vld", 32'(m_vld), 0);
    check("rst_m_sof", 32'(m_sof), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_st_vld", 32'(st_vld), 0);
    check("rst_st_len", 32'(st_len), 0);
    check("rst_st_err", 32'(st_err), 0);
    check("rst_cnt_good", 32'(cnt_good), 0);
    check("rst_cnt_bad", 32'(cnt_bad), 0);
    drive(2'b00, 0, 0, 0);
    repeat (2) drive(2'b00, 0, 0, 0);
    make_frame(60, 1);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    make_frame(60, 1);
    frame_q[63] = frame_q[63] ^ 8'h01;
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    make_frame(16, 0);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    make_frame(60, 0);
    expect_frame(1, 0, 30, -1);
    send_frame(31, 0, 30, -1, 4);
    settle();
    make_frame(60, 0);
    expect_frame(1, 2, -1, -1);
    send_frame(31, 2, -1, -1, 4);
    settle();
    make_raw(0);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    make_frame(60, 0);
    expect_frame(0, 0, -1, -1);
    send_frame(4, 0, -1, -1, 4);
    settle();
    make_frame(60, 0);
    expect_frame(1, 0, -1, -1);
    send_frame(5, 0, -1, -1, 4);
    settle();
    make_frame(1596, 0);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 1);
    make_frame(60, 0);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    make_frame(60, 0);
    expect_frame(1, 0, -1, 20);
    send_frame(31, 0, -1, 20, 4);
    settle();
    make_frame(60, 0);
    expect_frame(1, 0, -1, -1);
    send_frame(31, 0, -1, -1, 4);
    settle();
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 90);
      if (n >= 4) make_frame(n - 4, 0);
      else make_raw(n);
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, n - 1);
        frame_q[p] = frame_q[p] ^ 8'(1 << $urandom_range(0, 7));
      end
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      eb = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      expect_frame(1, extra, eb, -1);
      send_frame($urandom_range(5, 31), extra, eb, -1, $urandom_range(2, 6));
      settle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
